muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_addsub.sv | 24 ++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide unit
//
// Purpose: op encodings, FSM state encoding, iteration count and small op
// decode helpers used by muldiv_unit.
// Ports: none (package).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  // Bit 0 of the encoding clear means a signed op (MULT, DIV).
  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

  // Bit 1 of the encoding set means a divide (DIV, DIVU).
  function automatic logic is_div_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// rtl/muldiv_addsub.sv - shared add/subtract used by multiply and divide iterations
//
// Purpose: one W-bit adder that either adds or subtracts (two's complement).
// Ports:
//   i_a      W  first operand
//   i_b      W  second operand
//   i_sub    1  1: o_result = i_a - i_b, 0: o_result = i_a + i_b
//   o_result W  sum/difference, modulo 2^W
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_result
);

  logic [W-1:0] w_b_inv;

  // Subtract as a + ~b + 1 so a single carry chain serves both modes.
  assign w_b_inv  = i_b ^ {W{i_sub}};
  assign o_result = i_a + w_b_inv + W'(i_sub);

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Purpose: iterative shift-add multiply and restoring divide, one bit per
// cycle, results committed to HI/LO. Also services MTHI/MTLO writes in IDLE.
// Ports:
//   clk      1      clock, rising edge
//   rst      1      asynchronous active-high reset
//   start    1      launch operation (sampled only in IDLE)
//   op       2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   inputA   WIDTH  multiplicand / dividend
//   inputB   WIDTH  multiplier / divisor
//   hiWrite  1      MTHI: HI <= wrData (IDLE only)
//   loWrite  1      MTLO: LO <= wrData (IDLE only)
//   wrData   WIDTH  data for hiWrite/loWrite
//   busy     1      operation in progress
//   done     1      one-cycle pulse, HI/LO hold the new result
//   hi, lo   WIDTH  HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_count;
  op_e                r_op;
  // Multiply: full product. Divide: [2W-1:W] remainder, [W-1:0] dividend
  // bits shifting out on the left while quotient bits shift in on the right.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg_main;
  logic               r_neg_rem;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  op_e                w_op_in;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_b_zero;
  logic               w_is_div;
  logic [WIDTH:0]     w_as_a;
  logic [WIDTH:0]     w_as_b;
  logic [WIDTH:0]     w_as_res;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod_fixed;
  logic [WIDTH-1:0]   w_quo_fixed;
  logic [WIDTH-1:0]   w_rem_fixed;

  // ---------------- operand capture ----------------
  assign w_op_in  = op_e'(op);
  assign w_neg_a  = is_signed_op(w_op_in) & inputA[WIDTH-1];
  assign w_neg_b  = is_signed_op(w_op_in) & inputB[WIDTH-1];
  assign w_mag_a  = w_neg_a ? (~inputA + 1'b1) : inputA;
  assign w_mag_b  = w_neg_b ? (~inputB + 1'b1) : inputB;
  assign w_b_zero = (inputB == '0);

  // ---------------- shared iteration adder ----------------
  assign w_is_div = is_div_op(r_op);
  // Divide trial: {remainder, next dividend bit} - divisor.
  // Multiply: upper product half + multiplicand.
  assign w_as_a   = w_is_div ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_as_b   = {1'b0, r_opb};

  muldiv_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .i_a      (w_as_a),
    .i_b      (w_as_b),
    .i_sub    (w_is_div),
    .o_result (w_as_res)
  );

  // The trial value is always below twice the divisor, so the top bit of the
  // difference is set exactly when the subtraction went negative.
  assign w_borrow = w_as_res[WIDTH];

  always_comb begin
    w_acc_next = r_acc;
    if (w_is_div) begin
      w_acc_next = {(w_borrow ? r_acc[2*WIDTH-2:WIDTH-1] : w_as_res[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], ~w_borrow};
    end else if (r_acc[0]) begin
      w_acc_next = {w_as_res, r_acc[WIDTH-1:1]};
    end else begin
      w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

  // ---------------- sign correction ----------------
  assign w_prod_fixed = r_neg_main ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fixed  = r_neg_main ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fixed  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == CNT_W'(ITERATIONS - 1)) w_state_next = FIX;
      end
      FIX: begin
        busy         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_op       <= OP_MULT;
      r_acc      <= '0;
      r_opb      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hiWrite) r_hi <= wrData;
          if (loWrite) r_lo <= wrData;
          if (start) begin
            r_op      <= w_op_in;
            r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
            r_opb     <= w_mag_b;
            r_count   <= '0;
            // A zero divisor leaves quotient all-ones and remainder |A|;
            // skipping only the quotient fix makes HI come back as inputA.
            r_neg_main <= (w_neg_a ^ w_neg_b) & ~(is_div_op(w_op_in) & w_b_zero);
            r_neg_rem  <= w_neg_a;
          end
        end
        CALC: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CNT_W'(1);
        end
        FIX: begin
          if (w_is_div) begin
            r_hi <= w_rem_fixed;
            r_lo <= w_quo_fixed;
          end else begin
            r_hi <= w_prod_fixed[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fixed[WIDTH-1:0];
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
